// File: rtl/softmax_max_subtract_if.sv
// Valid/ready bundle between the softmax front stage and its neighbours.
// Input side carries logits in, output side carries x_i - max out.
interface softmax_max_subtract_if #(
    parameter int DATALENGTH = 32
);
    logic                  InValid;
    logic                  InReady;
    logic [DATALENGTH-1:0] InData;
    logic                  OutValid;
    logic                  OutReady;
    logic                  OutLast;
    logic [DATALENGTH-1:0] OutData;
    logic                  Busy;

    modport master (
        output InValid, InData, OutReady,
        input  InReady, OutValid, OutData, OutLast, Busy
    );

    modport slave (
        input  InValid, InData, OutReady,
        output InReady, OutValid, OutData, OutLast, Busy
    );
endinterface

// File: rtl/softmax_max_subtract.sv
// Softmax front stage: buffers N float32 logits, finds the max,
// then streams x_i - max through a handshaked float32 adder.
module adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        a_stb,
    input  logic        b_stb,
    output logic        a_ack,
    output logic        b_ack,
    output logic [31:0] z,
    output logic        z_stb,
    input  logic        z_ack
);
    typedef enum logic [1:0] {A_GET, A_CALC, A_PUT} add_state_t;

    add_state_t  r_st;
    logic [31:0] r_a, r_b, r_z, w_sum;
    logic        w_swap, w_st, w_up;
    logic [31:0] w_big, w_sml;
    logic [7:0]  w_ex, w_ey, w_d, w_exp;
    logic [26:0] w_mx, w_my, w_my_sh, w_m;
    logic [27:0] w_s;
    logic [8:0]  w_e;
    logic [24:0] w_r;

    assign a_ack = (r_st == A_GET) && b_stb;
    assign b_ack = (r_st == A_GET) && a_stb;
    assign z_stb = (r_st == A_PUT);
    assign z     = r_z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st <= A_GET;
            r_a  <= '0;
            r_b  <= '0;
            r_z  <= '0;
        end else begin
            unique case (r_st)
                A_GET: if (a_stb && b_stb) begin
                    r_a  <= a;
                    r_b  <= b;
                    r_st <= A_CALC;
                end
                A_CALC: begin
                    r_z  <= w_sum;
                    r_st <= A_PUT;
                end
                A_PUT: if (z_ack) r_st <= A_GET;
                default: r_st <= A_GET;
            endcase
        end
    end

    // Guard/round/sticky add with round-to-nearest-even; larger magnitude first
    always_comb begin
        w_swap  = r_b[30:0] > r_a[30:0];
        w_big   = w_swap ? r_b : r_a;
        w_sml   = w_swap ? r_a : r_b;
        w_ex    = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
        w_ey    = (w_sml[30:23] == 8'd0) ? 8'd1 : w_sml[30:23];
        w_mx    = {w_big[30:23] != 8'd0, w_big[22:0], 3'b000};
        w_my    = {w_sml[30:23] != 8'd0, w_sml[22:0], 3'b000};
        w_d     = w_ex - w_ey;
        w_st    = 1'b0;
        for (int k = 0; k < 27; k++)
            if (8'(k) < w_d) w_st = w_st | w_my[k];
        w_my_sh = (w_d > 8'd26) ? 27'd0 : (w_my >> w_d);
        w_my_sh[0] = w_my_sh[0] | w_st;
        if (w_big[31] == w_sml[31])
            w_s = {1'b0, w_mx} + {1'b0, w_my_sh};
        else
            w_s = {1'b0, w_mx} - {1'b0, w_my_sh};
        w_e = {1'b0, w_ex};
        if (w_s[27]) begin
            w_m = {w_s[27:2], w_s[1] | w_s[0]};
            w_e = w_e + 9'd1;
        end else begin
            w_m = w_s[26:0];
            for (int k = 0; k < 26; k++)
                if (!w_m[26] && w_e > 9'd1) begin
                    w_m = w_m << 1;
                    w_e = w_e - 9'd1;
                end
        end
        w_up  = w_m[2] && (w_m[1] || w_m[0] || w_m[3]);
        w_r   = {1'b0, w_m[26:3]} + 25'(w_up);
        w_exp = w_r[24] ? (w_e[7:0] + 8'd1)
              : (w_r[23] ? w_e[7:0] : 8'd0);
        if (w_s == 28'd0)
            w_sum = 32'h0000_0000;
        else if (w_r[24])
            w_sum = {w_big[31], w_exp, w_r[23:1]};
        else
            w_sum = {w_big[31], w_exp, w_r[22:0]};
    end
endmodule

module softmax_max_subtract #(
    parameter int N          = 10,
    parameter int DATALENGTH = 32
) (
    input  logic Clock,
    input  logic Reset,
    softmax_max_subtract_if.slave io_bus
);
    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, OUT} state_t;

    state_t                r_state, w_nx_state;
    logic [DATALENGTH-1:0] r_buf [N];
    logic [CW-1:0]         r_cnt, w_nx_cnt;
    logic [IW-1:0]         r_idx, w_nx_idx;
    logic [31:0]           r_max, w_nx_max;
    logic [31:0]           r_op_a, w_nx_op_a;
    logic [31:0]           r_op_b, w_nx_op_b;
    logic [31:0]           r_out_data, w_nx_out_data;
    logic                  r_in_ready, w_nx_in_ready;
    logic                  r_out_valid, w_nx_out_valid;
    logic                  r_out_last, w_nx_out_last;
    logic                  r_busy, w_nx_busy;
    logic                  r_a_stb, w_nx_a_stb;
    logic                  r_b_stb, w_nx_b_stb;
    logic                  r_z_ack, w_nx_z_ack;
    logic                  w_xfer, w_last;
    logic [31:0]           w_cur, w_z;
    logic                  w_a_ack, w_b_ack, w_z_stb;

    function automatic logic f_zero(input logic [31:0] x);
        return x[30:0] == 31'd0;
    endfunction

    // Sign/magnitude order; +0 and -0 are equal
    function automatic logic f_gt(input logic [31:0] x,
                                  input logic [31:0] y);
        if (f_zero(x) && f_zero(y)) return 1'b0;
        if (x[31] != y[31])        return !x[31];
        if (!x[31])                return x[30:0] > y[30:0];
        return x[30:0] < y[30:0];
    endfunction

    adder u_adder (
        .clk   (Clock),
        .rst   (~Reset),
        .a     (r_op_a),
        .b     (r_op_b),
        .a_stb (r_a_stb),
        .b_stb (r_b_stb),
        .a_ack (w_a_ack),
        .b_ack (w_b_ack),
        .z     (w_z),
        .z_stb (w_z_stb),
        .z_ack (r_z_ack)
    );

    assign w_cur = r_buf[r_idx];
    assign w_last = (r_idx == IW'(N - 1));

    assign io_bus.InReady  = r_in_ready;
    assign io_bus.OutValid = r_out_valid;
    assign io_bus.OutData  = r_out_data;
    assign io_bus.OutLast  = r_out_last;
    assign io_bus.Busy     = r_busy;

    always_comb begin
        w_nx_state     = r_state;
        w_nx_cnt       = r_cnt;
        w_nx_idx       = r_idx;
        w_nx_max       = r_max;
        w_nx_op_a      = r_op_a;
        w_nx_op_b      = r_op_b;
        w_nx_out_data  = r_out_data;
        w_nx_out_valid = r_out_valid;
        w_nx_out_last  = r_out_last;
        w_nx_a_stb     = r_a_stb;
        w_nx_b_stb     = r_b_stb;
        w_nx_z_ack     = 1'b0;
        w_xfer         = io_bus.InValid && r_in_ready;
        unique case (r_state)
            IDLE: if (w_xfer) begin
                w_nx_max   = io_bus.InData;
                w_nx_cnt   = CW'(1);
                w_nx_state = LOAD;
            end
            LOAD: if (w_xfer) begin
                if (f_gt(io_bus.InData, r_max))
                    w_nx_max = io_bus.InData;
                w_nx_cnt = r_cnt + 1'b1;
                if (r_cnt == CW'(N - 1)) w_nx_state = ISSUE;
            end
            ISSUE: begin
                if (w_cur == r_max || (f_zero(w_cur) && f_zero(r_max))) begin
                    w_nx_out_data  = 32'h0000_0000;
                    w_nx_out_valid = 1'b1;
                    w_nx_out_last  = w_last;
                    w_nx_state     = OUT;
                end else begin
                    w_nx_op_a  = w_cur;
                    w_nx_op_b  = {~r_max[31], r_max[30:0]};
                    w_nx_a_stb = 1'b1;
                    w_nx_b_stb = 1'b1;
                    w_nx_state = WAIT;
                end
            end
            WAIT: begin
                if (w_a_ack) w_nx_a_stb = 1'b0;
                if (w_b_ack) w_nx_b_stb = 1'b0;
                if (w_z_stb) begin
                    w_nx_out_data  = w_z;
                    w_nx_z_ack     = 1'b1;
                    w_nx_out_valid = 1'b1;
                    w_nx_out_last  = w_last;
                    w_nx_state     = OUT;
                end
            end
            OUT: if (io_bus.OutReady) begin
                w_nx_out_valid = 1'b0;
                w_nx_out_last  = 1'b0;
                if (w_last) begin
                    w_nx_idx   = '0;
                    w_nx_cnt   = '0;
                    w_nx_state = IDLE;
                end else begin
                    w_nx_idx   = r_idx + 1'b1;
                    w_nx_state = ISSUE;
                end
            end
            default: w_nx_state = IDLE;
        endcase
        w_nx_in_ready = (w_nx_state == IDLE) || (w_nx_state == LOAD);
        w_nx_busy     = (w_nx_state != IDLE);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_max       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_out_data  <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_a_stb     <= 1'b0;
            r_b_stb     <= 1'b0;
            r_z_ack     <= 1'b0;
        end else begin
            r_state     <= w_nx_state;
            r_cnt       <= w_nx_cnt;
            r_idx       <= w_nx_idx;
            r_max       <= w_nx_max;
            r_op_a      <= w_nx_op_a;
            r_op_b      <= w_nx_op_b;
            r_out_data  <= w_nx_out_data;
            r_in_ready  <= w_nx_in_ready;
            r_out_valid <= w_nx_out_valid;
            r_out_last  <= w_nx_out_last;
            r_busy      <= w_nx_busy;
            r_a_stb     <= w_nx_a_stb;
            r_b_stb     <= w_nx_b_stb;
            r_z_ack     <= w_nx_z_ack;
        end
    end

    // Buffer contents need no reset; cnt gates every write
    always_ff @(posedge Clock) begin
        if (w_xfer) r_buf[r_cnt[IW-1:0]] <= io_bus.InData;
    end
endmodule

// File: tb/tb_softmax_max_subtract.sv
// Scoreboard bench for softmax_max_subtract: N=4 and N=10 instances,
// expected words queued at issue time and checked by a monitor.
module tb_softmax_max_subtract;
    logic Clock;
    logic Reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   bp4     = 1'b0;
    int   cyc     = 0;

    logic [32:0] q4 [$];
    logic [32:0] q10 [$];

    softmax_max_subtract_if #(.DATALENGTH(32)) bus4 ();
    softmax_max_subtract_if #(.DATALENGTH(32)) bus10 ();

    softmax_max_subtract #(.N(4), .DATALENGTH(32)) u_n4 (
        .Clock (Clock),
        .Reset (Reset),
        .io_bus(bus4)
    );

    softmax_max_subtract #(.N(10), .DATALENGTH(32)) u_n10 (
        .Clock (Clock),
        .Reset (Reset),
        .io_bus(bus10)
    );

    logic [31:0] v_basic [10] = '{32'h3f800000, 32'h40400000,
        32'h40000000, 32'hbf800000, 0, 0, 0, 0, 0, 0};
    logic [31:0] e_basic [10] = '{32'hc0000000, 32'h00000000,
        32'hbf800000, 32'hc0800000, 0, 0, 0, 0, 0, 0};
    logic [31:0] v_neg [10] = '{32'hbf800000, 32'hc0000000,
        32'hbf000000, 32'hc0400000, 0, 0, 0, 0, 0, 0};
    logic [31:0] e_neg [10] = '{32'hbf000000, 32'hbfc00000,
        32'h00000000, 32'hc0200000, 0, 0, 0, 0, 0, 0};
    logic [31:0] v_tie [10] = '{32'h80000000, 32'h00000000,
        32'hbf800000, 32'h80000000, 0, 0, 0, 0, 0, 0};
    logic [31:0] e_tie [10] = '{32'h00000000, 32'h00000000,
        32'hbf800000, 32'h00000000, 0, 0, 0, 0, 0, 0};
    // 1, 2.5, -4, 8, 0.25, 5, -1, 8, 0.5, 7.75 ; max = 8
    logic [31:0] v_ten [10] = '{32'h3f800000, 32'h40200000,
        32'hc0800000, 32'h41000000, 32'h3e800000, 32'h40a00000,
        32'hbf800000, 32'h41000000, 32'h3f000000, 32'h40f80000};
    logic [31:0] e_ten [10] = '{32'hc0e00000, 32'hc0b00000,
        32'hc1400000, 32'h00000000, 32'hc0f80000, 32'hc0400000,
        32'hc1100000, 32'h00000000, 32'hc0f00000, 32'hbe800000};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drv(input bit big, input logic v, input logic [31:0] d);
        if (big) begin
            bus10.InValid = v;
            bus10.InData  = d;
        end else begin
            bus4.InValid = v;
            bus4.InData  = d;
        end
    endtask

    task automatic feed(input bit big, input logic [31:0] x [10],
                        input logic [31:0] e [10], input int n,
                        input int gap);
        int t;
        for (int k = 0; k < n; k++) begin
            if (big) q10.push_back({k == n - 1, e[k]});
            else     q4.push_back({k == n - 1, e[k]});
        end
        for (int k = 0; k < n; k++) begin
            while (gap > 0 && $urandom_range(99) < gap) begin
                drv(big, 1'b0, 32'h0);
                @(posedge Clock); #1;
            end
            drv(big, 1'b1, x[k]);
            t = 0;
            while (!(big ? bus10.InReady : bus4.InReady) && t < 500) begin
                @(posedge Clock); #1;
                t++;
            end
            if (t >= 500) begin
                n_tests++;
                n_fail++;
                $display("FAIL feed timeout word=%0d got InReady=0 required 1", k);
            end
            @(posedge Clock); #1;
        end
        drv(big, 1'b0, 32'h0);
    endtask

    task automatic drain(input bit big, input string nm);
        int t = 0;
        while ((big ? (q10.size() != 0 || bus10.Busy)
                    : (q4.size() != 0 || bus4.Busy)) && t < 2000) begin
            @(posedge Clock);
            t++;
        end
        #1;
        chk({nm, " words left"}, big ? q10.size() : q4.size(), 32'd0);
    endtask

    task automatic mon(input bit big);
        logic [32:0] e;
        int          sz;
        sz = big ? q10.size() : q4.size();
        if (sz == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s extra word: got %h required none",
                     big ? "n10" : "n4", big ? bus10.OutData : bus4.OutData);
        end else begin
            e = big ? q10[0] : q4[0];
            if (big) begin
                chk("n10 data", bus10.OutData, e[31:0]);
                chk("n10 last", 32'(bus10.OutLast), 32'(e[32]));
                chk("n10 inready", 32'(bus10.InReady), 32'd0);
                if (bus10.OutReady) void'(q10.pop_front());
            end else begin
                chk("n4 data", bus4.OutData, e[31:0]);
                chk("n4 last", 32'(bus4.OutLast), 32'(e[32]));
                chk("n4 inready", 32'(bus4.InReady), 32'd0);
                if (bus4.OutReady) void'(q4.pop_front());
            end
        end
    endtask

    always @(negedge Clock) begin
        if (Reset && bus4.OutValid)  mon(1'b0);
        if (Reset && bus10.OutValid) mon(1'b1);
    end

    initial begin
        bus4.OutReady  = 1'b1;
        bus10.OutReady = 1'b1;
        forever begin
            @(posedge Clock); #1;
            cyc++;
            bus4.OutReady  = bp4 ? (cyc % 3 == 0) : 1'b1;
            bus10.OutReady = 1'b1;
        end
    end

    task automatic chk_reset(input string nm);
        chk({nm, " n4 InReady"},  32'(bus4.InReady),  32'd0);
        chk({nm, " n4 OutValid"}, 32'(bus4.OutValid), 32'd0);
        chk({nm, " n4 OutData"},  bus4.OutData,       32'd0);
        chk({nm, " n4 OutLast"},  32'(bus4.OutLast),  32'd0);
        chk({nm, " n4 Busy"},     32'(bus4.Busy),     32'd0);
        chk({nm, " n10 InReady"}, 32'(bus10.InReady), 32'd0);
        chk({nm, " n10 Busy"},    32'(bus10.Busy),    32'd0);
    endtask

    initial begin
        int t;
        Reset = 1'b0;
        drv(1'b0, 1'b0, 32'h0);
        drv(1'b1, 1'b0, 32'h0);
        repeat (3) @(posedge Clock);
        #1;
        chk_reset("por");
        Reset = 1'b1;
        @(posedge Clock); #1;
        chk("n4 InReady after release", 32'(bus4.InReady), 32'd1);
        chk("n10 InReady after release", 32'(bus10.InReady), 32'd1);

        feed(1'b0, v_basic, e_basic, 4, 0);
        drain(1'b0, "basic");
        feed(1'b0, v_neg, e_neg, 4, 0);
        drain(1'b0, "negative");
        feed(1'b0, v_tie, e_tie, 4, 0);
        drain(1'b0, "ties");

        bp4 = 1'b1;
        feed(1'b0, v_basic, e_basic, 4, 0);
        drain(1'b0, "backpressure");
        bp4 = 1'b0;

        feed(1'b0, v_basic, e_basic, 4, 0);
        t = 0;
        while (q4.size() > 2 && t < 500) begin
            @(posedge Clock);
            t++;
        end
        #1;
        chk("midreset two words out", q4.size(), 32'd2);
        Reset = 1'b0;
        q4.delete();
        #1;
        chk_reset("midreset");
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(posedge Clock); #1;
        chk("n4 InReady after midreset", 32'(bus4.InReady), 32'd1);
        feed(1'b0, v_neg, e_neg, 4, 0);
        drain(1'b0, "after reset");

        feed(1'b1, v_ten, e_ten, 10, 40);
        drain(1'b1, "gaps 1");
        feed(1'b1, v_ten, e_ten, 10, 60);
        drain(1'b1, "gaps 2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/softmax_max_subtract.md
# softmax_max_subtract

Front stage of the softmax datapath. It buffers one vector of `N` IEEE-754 single-precision logits and finds their maximum. It then streams out `x_i - max` in arrival order, one word per handshake, into the exponential stage. Every output is ≤ 0, so the exponential's Taylor approximation operates in its accurate range and cannot overflow.

## Interface
- `N`, default 10: logits per vector, must be ≥ 2.
- `DATALENGTH`, default 32: word width; only 32 (float32) is supported.
- `Clock`  in  1: clock, rising edge.
- `Reset`  in  1: asynchronous, active-low.
- `InValid`  in  1: `InData` valid.
- `InData`  in  32: float32 logit.
- `InReady`  out  1: block accepts `InData` this cycle.
- `OutValid`  out  1: `OutData` valid; held until accepted.
- `OutData`  out  32: float32 `x_i - max`.
- `OutReady`  in  1: downstream accepts `OutData`.
- `OutLast`  out  1: qualifies the final (`N`-th) output of a vector.
- `Busy`  out  1: high in every state except IDLE.

## Operation
- FSM states: IDLE, LOAD, ISSUE, WAIT, OUT.
- IDLE:
  - `InReady`=1.
  - A transfer (`InValid && InReady`) writes `buf[0]`, sets `max` = `InData` and `cnt`=1, then moves to LOAD.
- LOAD:
  - `InReady`=1.
  - Each transfer writes `buf[cnt]`, updates `max`, and increments `cnt`.
  - When `cnt` reaches `N`, `InReady` drops in the same cycle and the FSM moves to ISSUE.
- Max compare is pure sign/magnitude:
  - `a > b` if signs differ and `a` is positive.
  - Both positive: `a[30:0] > b[30:0]`.
  - Both negative: `a[30:0] < b[30:0]`.
  - +0 and −0 compare equal.
  - On a tie, the first-seen value is kept.
  - NaN/Inf handling is undefined; the bench excludes them.
- ISSUE, for index `i`:
  - If `buf[i] == max` bitwise, or both are zeros of either sign, `OutData` = 32'h00000000 directly and the FSM goes to OUT. The adder is bypassed.
  - Otherwise, drive the team float32 `adder` with `a`=`buf[i]`, `b`={~max[31], max[30:0]}, and `a_stb`=`b_stb`=1. The adder `rst` is driven by `~Reset`. Go to WAIT.
- WAIT:
  - Drop each strobe once its ack is seen.
  - On `z_stb`, capture `z` into `OutData`, pulse `z_ack` for one cycle, and go to OUT.
- OUT:
  - `OutValid`=1, and `OutLast`=1 iff `i == N-1`.
  - On `OutReady`: if `i < N-1`, increment `i` and go to ISSUE; else go to IDLE.
- `OutData` and `OutLast` are stable while `OutValid && !OutReady`.
- A new vector is not accepted until the last output is transferred.

## Timing
- Reset values:
  - `InReady`=0 while `Reset` is low, then 1 from the first clock after release (IDLE).
  - `OutValid`=0, `OutData`=0, `OutLast`=0, `Busy`=0.
  - `cnt`=0, `i`=0, `max`=0, adder strobes 0.
- All outputs are registered.
- Load takes `N` cycles at full rate. Input stalls (`InValid`=0) simply hold state.
- First `OutValid` timing:
  - Bypass element: 2 cycles after the `N`-th input transfer (ISSUE, then OUT).
  - Adder element: 2 cycles plus the adder latency.
- Per-element throughput is bounded by adder latency plus 2 cycles. Back-pressure adds cycles one for one.
- Asserting `Reset` in any state aborts immediately:
  - The buffer contents are discarded.
  - The in-flight adder operation is abandoned through the adder's own reset.
  - After release the block restarts in IDLE with `cnt`=0.
- `InValid` while in ISSUE/WAIT/OUT is ignored (`InReady`=0). The upstream must hold its data.

## Test plan
- Basic, `N`=4:
  - Input 3f800000, 40400000, 40000000, bf800000 (1, 3, 2, −1).
  - Required output c0000000, 00000000, bf800000, c0800000.
  - `OutLast` only on the 4th output.
- All negative, `N`=4:
  - Input bf800000, c0000000, bf000000, c0400000.
  - Max = −0.5; required output bf000000, bfc00000, 00000000, c0200000.
- Ties and signed zero, `N`=4:
  - Input 80000000, 00000000, bf800000, 80000000.
  - Required output 00000000, 00000000, bf800000, 00000000.
- Back-pressure:
  - Use the basic vector with `OutReady` toggled 1-in-3 cycles.
  - Required: identical values in order, `OutData` stable while stalled, and `InReady`=0 until the final transfer.
- Reset mid-stream:
  - Assert `Reset` after 2 outputs of a vector, then release and send a fresh vector.
  - Required: all outputs return to their reset values, and the fresh vector's results are correct and unaffected.
- Input gaps:
  - Use `N`=10 with `InValid` dropping randomly.
  - Required: outputs match a reference model of `x_i − max` bit-exactly, with no extra or missing words.
